// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display converter.
// Holds the FSM state encoding, default widths, range limit and error fill.
package bcd_pkg;

    localparam int IN_W_DEF   = 27;
    localparam int DIGITS_DEF = 8;

    // Largest value that fits in eight decimal digits.
    localparam logic [63:0] MAX_VAL = 64'd99_999_999;

    // Shown on the display when the input is out of range.
    localparam logic [31:0] ERR_PATTERN = 32'hEEEE_EEEE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is >= 5.
// Ports: din (nibble before shift), dout (corrected nibble).
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // A nibble of at most 9 plus 3 stays within 4 bits, so no carry out.
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/gpio_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for a 7-seg display.
// Ports: clk, rst_n (async low), start, bin_in -> busy, done, bcd_out, ovf.
module gpio_bcd_conv
    import bcd_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t state_q;
    state_t state_d;

    logic [IN_W-1:0]       bin_q;
    logic [ACC_W-1:0]      acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ACC_W-1:0]      acc_adj;
    logic [ACC_W+IN_W-1:0] shifted;
    logic [ACC_W-1:0]      acc_nxt;
    logic [IN_W-1:0]       bin_nxt;

    logic accept;
    logic in_range;
    logic last;

    // Start is honoured only between conversions; SHIFT ignores it.
    assign accept   = start && (state_q == IDLE || state_q == DONE);
    assign in_range = 64'(bin_in) <= MAX_VAL;
    assign last     = (cnt_q == CNT_W'(1));

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (acc_q[4*g +: 4]),
                .dout (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // Correct first, then shift the whole {bcd, binary} pair left by one.
    assign shifted = {acc_adj, bin_q} << 1;
    assign acc_nxt = shifted[ACC_W+IN_W-1:IN_W];
    assign bin_nxt = shifted[IN_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = in_range ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = in_range ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            bin_q <= bin_in;
            acc_q <= '0;
            cnt_q <= CNT_W'(IN_W);
            // Out-of-range values skip the shift phase entirely.
            if (!in_range) begin
                bcd_out <= {DIGITS{ERR_PATTERN[3:0]}};
                ovf     <= 1'b1;
            end
        end else if (state_q == SHIFT) begin
            acc_q <= acc_nxt;
            bin_q <= bin_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
            // Publish only the final accumulator, never partial sums.
            if (last) begin
                bcd_out <= acc_nxt;
                ovf     <= 1'b0;
            end
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_gpio_bcd_conv.sv
// Self-checking bench for gpio_bcd_conv: vector table plus corner sequences.
// Expected results are queued at stimulus time and checked on each done.
module tb_gpio_bcd_conv;

    localparam int IN_W   = 27;
    localparam int DIGITS = 8;
    localparam int MAXV   = 99_999_999;

    typedef struct {
        logic [IN_W-1:0] bin;
        logic [31:0]     bcd;
        logic            ovf;
    } vec_t;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          s;
        int          lat;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [IN_W-1:0]   bin_in;
    logic              busy;
    logic              done;
    logic [31:0]       bcd_out;
    logic              ovf;

    int   nchk;
    int   nerr;
    int   cyc;
    exp_t sb[$];
    vec_t tbl[9];

    gpio_bcd_conv #(
        .IN_W   (IN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        if (v > MAXV) return 32'hEEEE_EEEE;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest entry.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL spurious_done: got done=1 expected no done (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bcd_out", bcd_out, e.bcd);
                chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
                chk("latency", 32'(cyc - e.s + 1), 32'(e.lat));
            end
        end
    end

    task automatic push_exp(input int v);
        exp_t e;
        e.bcd = ref_bcd(v);
        e.ovf = (v > MAXV);
        e.s   = cyc + 1;
        e.lat = (v > MAXV) ? 1 : IN_W + 1;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_conv(input vec_t v);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v.bin;
        e.bcd  = v.bcd;
        e.ovf  = v.ovf;
        e.s    = cyc + 1;
        e.lat  = v.ovf ? 1 : IN_W + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done_timeout", {31'b0, done}, 32'd1);
    endtask

    initial begin
        nchk   = 0;
        nerr   = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;

        tbl[0] = '{27'd0,           32'h0000_0000, 1'b0};
        tbl[1] = '{27'h3FFFF,       32'h0026_2143, 1'b0};
        tbl[2] = '{27'd99_999_999,  32'h9999_9999, 1'b0};
        tbl[3] = '{27'd100_000_000, 32'hEEEE_EEEE, 1'b1};
        tbl[4] = '{27'd12_345_678,  32'h1234_5678, 1'b0};
        tbl[5] = '{27'h7FF_FFFF,    32'hEEEE_EEEE, 1'b1};
        tbl[6] = '{27'd1,           32'h0000_0001, 1'b0};
        tbl[7] = '{27'd10,          32'h0000_0010, 1'b0};
        tbl[8] = '{27'd90_909_090,  32'h9090_9090, 1'b0};

        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_bcd", bcd_out, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_conv(tbl[i]);
        end

        // Start and new bin_in during SHIFT must be ignored.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd12345;
        push_exp(12345);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        chk("mid_bcd_hold", bcd_out, 32'h0909_0909 ^ 32'h9999_9999);
        start  = 1'b1;
        bin_in = 27'd777;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 27'd4242;
        drain();
        repeat (5) @(negedge clk);
        chk("hold_bcd", bcd_out, 32'h0001_2345);
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Reset in the middle of a conversion aborts it.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd55555;
        push_exp(55555);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_bcd", bcd_out, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (35) @(negedge clk);
        chk("abort_no_done_bcd", bcd_out, 32'd0);
        run_conv(tbl[4]);

        // Start held high: back-to-back conversions.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd99_999_999;
        push_exp(99_999_999);
        for (int i = 0; i < 6; i++) begin
            wait_done();
            if (i < 5) begin
                int v;
                v = int'($urandom_range(MAXV, 0));
                bin_in = IN_W'(v);
                push_exp(v);
            end else begin
                start = 1'b0;
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpio_bcd_conv.md
GPIO_BCD_CONV -- requirements
Module: gpio_bcd_conv

Interface
REQ-001 Parameter: IN_W, 27, width of binary input (covers 0..99,999,999).
REQ-002 Parameter: DIGITS, 8, number of BCD output nibbles (one per seven-segment digit).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request conversion of bin_in; sampled on rising clk.
REQ-006 Port: bin_in  input  IN_W  binary value (the zero-extended switch value) to convert.
REQ-007 Port: busy  output  1  high while a conversion is in progress.
REQ-008 Port: done  output  1  one-cycle pulse when bcd_out/ovf become valid.
REQ-009 Port: bcd_out  output  4*DIGITS  packed BCD result; nibble 0 = least-significant decimal digit, feeds the 32-bit gpio_out display word.
REQ-010 Port: ovf  output  1  high when the last accepted bin_in exceeded 99,999,999.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE; only IDLE and DONE accept start.
REQ-012 On start in an accepting state, bin_in SHALL be captured into an internal shift register, and the BCD accumulator and iteration counter (IN_W) SHALL be cleared/loaded.
REQ-013 If captured value <= 99,999,999: next state SHIFT, busy=1.
REQ-014 If captured value > 99,999,999: next state DONE directly, ovf=1, bcd_out=0xEEEE_EEEE; done asserts the cycle after start is sampled.
REQ-015 Each SHIFT cycle: every BCD nibble >= 5 gets +3, then {accumulator, binary} shifts left one bit; counter decrements.
REQ-016 After exactly IN_W SHIFT cycles, next state DONE; start sampled at cycle 0 gives done=1 at cycle IN_W+1 (28 for defaults).
REQ-017 In DONE: done=1 for that single cycle, busy=0, bcd_out updated in the same cycle done rises; next state IDLE unless start is high (then REQ-012 applies).
REQ-018 bcd_out and ovf SHALL hold their last result until the next done pulse; no intermediate accumulator values visible on bcd_out.
REQ-019 start while in SHIFT SHALL be ignored (no queueing, no restart, bin_in changes have no effect).
REQ-020 ovf SHALL clear to 0 on every in-range completion.
REQ-021 Arithmetic: accumulator width 4*DIGITS; nibble add-3 never carries across nibbles; no nibble of a valid result exceeds 9.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, ovf=0, bcd_out=0, counter=0, shift registers=0.
REQ-023 Reset mid-conversion SHALL abort with no done pulse; first start after release converts normally.

Structure
REQ-024 Package bcd_pkg SHALL hold the state enum, IN_W/DIGITS defaults, MAX_VAL (99,999,999) and ERR_PATTERN (0xEEEE_EEEE).
REQ-025 One sub-module bcd_digit_adj (4-bit in, 4-bit out, +3 if >= 5) SHALL be instantiated DIGITS times via generate.
REQ-026 Datapath and FSM in one file; target 150-250 RTL lines.

Verification
REQ-027 start, bin_in=0 -> done at cycle 28, bcd_out=0x0000_0000, ovf=0.
REQ-028 bin_in=0x3FFFF (262,143) -> bcd_out=0x0026_2143 at cycle 28; then bin_in=99,999,999 -> 0x9999_9999.
REQ-029 bin_in=100,000,000 -> done at cycle 1, ovf=1, bcd_out=0xEEEE_EEEE; next in-range start clears ovf.
REQ-030 start pulsed at cycle 10 with different bin_in during SHIFT -> ignored; original result at cycle 28.
REQ-031 rst_n low at cycle 10 of conversion -> busy=0, bcd_out=0, no done; restart converts 12345678 -> 0x1234_5678.
REQ-032 start held high continuously -> back-to-back conversions, done every 28 cycles, results match reference model.
